// File: rtl/rv32i_multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences the shared ALU, unified
// memory port and datapath registers, stretching memory states on mem_ready.
module rv32i_multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        JALR     = 4'd11,
        JALRLINK = 4'd12,
        LUI      = 4'd13,
        ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t state_q, state_d;
    logic   illegal_q;
    logic   pcUpdate, branch, irWriteRaw, regWriteRaw, memWriteRaw;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = JALR;
                    OP_LUI:       state_d = LUI;
                    OP_AUIPC:     state_d = ALUWB;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            JALR:     state_d = JALRLINK;
            JALRLINK: state_d = ALUWB;
            LUI:      state_d = FETCH;
            ILLEGAL:  state_d = ILLEGAL;
            default:  state_d = FETCH;
        endcase
    end

    // The illegal flag is raised on the same edge that enters ILLEGAL and only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ILLEGAL) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        case (opcode)
            OP_SW:            ImmSrc = 3'b001;
            OP_BEQ:           ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        pcUpdate    = 1'b0;
        branch      = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        memWriteRaw = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                irWriteRaw = mem_ready;
                pcUpdate   = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc   = 2'b01;
                regWriteRaw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                memWriteRaw = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB:    regWriteRaw = 1'b1;
            // PC loads the target already in ALUOut while the ALU forms the link OldPC+4.
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcUpdate = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcUpdate  = 1'b1;
            end
            JALRLINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            LUI: begin
                ResultSrc   = 2'b11;
                regWriteRaw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset aborts whatever is in flight, so no strobe may fire during a reset cycle.
    assign PCWrite  = ~reset & ((branch & Zero) | pcUpdate);
    assign IRWrite  = ~reset & irWriteRaw;
    assign RegWrite = ~reset & regWriteRaw;
    assign MemWrite = ~reset & memWriteRaw;
    assign illegal  = illegal_q;
    assign state    = state_q;

endmodule
